// File: rtl/dmem_requester.sv
// dmem_requester: MEM-stage initiator for the multi-cycle data RAM.
// Optional macro DMEM_TIMEOUT_EN aborts accesses that stay busy for TIMEOUT ACCESS cycles.
module dmem_requester #(
    parameter int WIDTH     = 32,
    parameter int ADDRWIDTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cpu_read_i,
    input  logic                 cpu_write_i,
    input  logic [ADDRWIDTH-1:0] cpu_addr_i,
    input  logic [WIDTH-1:0]     cpu_wdata_i,
    output logic                 stall_o,
    output logic [WIDTH-1:0]     cpu_rdata_o,
    output logic                 cpu_rdata_valid_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [ADDRWIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic                 mem_busy_i,
    input  logic [WIDTH-1:0]     mem_rdata_i,
    output logic                 err_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t           state_q;
    logic             op_write_q;
    logic [WIDTH-1:0] rdata_q;
    logic             timeout_hit;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    // Counter sits at zero in IDLE, so it reads k in the k-th ACCESS cycle (k from 0).
    assign timeout_hit = (state_q == ACCESS) && mem_busy_i && (cnt_q == 8'(TIMEOUT - 1));
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write takes priority when both requests are present.
                    if (cpu_write_i || cpu_read_i) begin
                        op_write_q  <= cpu_write_i;
                        mem_write_o <= cpu_write_i;
                        mem_read_o  <= ~cpu_write_i;
                        mem_addr_o  <= cpu_addr_i;
                        mem_wdata_o <= cpu_wdata_i;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (timeout_hit || !mem_busy_i) begin
                        mem_read_o  <= 1'b0;
                        mem_write_o <= 1'b0;
                        state_q     <= (op_write_q || timeout_hit) ? IDLE : RDATA;
                    end
                end
                RDATA: begin
                    rdata_q <= mem_rdata_i;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            IDLE:    stall_o = cpu_read_i | cpu_write_i;
            ACCESS:  stall_o = (mem_busy_i | ~op_write_q) & ~timeout_hit;
            default: stall_o = 1'b0;
        endcase
    end

    assign cpu_rdata_valid_o = (state_q == RDATA);
    assign cpu_rdata_o       = (state_q == RDATA) ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_dmem_requester.sv
// tb_dmem_requester: directed bench for dmem_requester with a delay-3 RAM responder.
// Build with DMEM_TIMEOUT_EN to also exercise the timeout abort (TIMEOUT=8).
module tb_dmem_requester;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_read_i;
    logic        cpu_write_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        stall_o;
    logic [31:0] cpu_rdata_o;
    logic        cpu_rdata_valid_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_busy_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    dmem_requester #(
        .WIDTH     (32),
        .ADDRWIDTH (32),
        .TIMEOUT   (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .cpu_read_i        (cpu_read_i),
        .cpu_write_i       (cpu_write_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_wdata_i       (cpu_wdata_i),
        .stall_o           (stall_o),
        .cpu_rdata_o       (cpu_rdata_o),
        .cpu_rdata_valid_o (cpu_rdata_valid_o),
        .mem_read_o        (mem_read_o),
        .mem_write_o       (mem_write_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_busy_i        (mem_busy_i),
        .mem_rdata_i       (mem_rdata_i),
        .err_o             (err_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM responder: busy for 3 cycles after the request appears, read data one cycle after busy falls.
    logic [31:0] mem [256];
    logic [7:0]  rcnt;
    logic        rvalid;
    logic [31:0] rreg;
    logic        busy_forever = 1'b0;

    assign mem_busy_i  = (mem_read_o | mem_write_o) && (busy_forever || rcnt < 8'd3);
    assign mem_rdata_i = rvalid ? rreg : 32'hBAD0_BAD0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rcnt   <= '0;
            rvalid <= 1'b0;
            rreg   <= '0;
        end else begin
            rvalid <= 1'b0;
            if (mem_read_o | mem_write_o) begin
                if (mem_busy_i) begin
                    rcnt <= rcnt + 8'd1;
                end else begin
                    rcnt <= '0;
                    if (mem_read_o) begin
                        rreg   <= mem[mem_addr_o[7:0]];
                        rvalid <= 1'b1;
                    end
                end
            end else begin
                rcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_write_o && !mem_busy_i) begin
            mem[mem_addr_o[7:0]] <= mem_wdata_o;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations gathered by run_op.
    int          r_stall, r_req, r_lead, r_vld;
    logic [31:0] r_vld_data;
    logic        r_rd_seen, r_wr_seen, r_last_req, r_ok;

    // Call at posedge+1; samples each negedge until stall_o drops, returns at posedge+1.
    task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic seen_req;
        r_stall = 0; r_req = 0; r_lead = 0; r_vld = 0; r_vld_data = '0;
        r_rd_seen = 1'b0; r_wr_seen = 1'b0; r_last_req = 1'b0; r_ok = 1'b0;
        seen_req = 1'b0;
        cpu_write_i = wr; cpu_read_i = rd; cpu_addr_i = addr; cpu_wdata_i = wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (stall_o) r_stall++;
            r_last_req = mem_read_o | mem_write_o;
            if (r_last_req) begin
                r_req++;
                seen_req = 1'b1;
            end else if (!seen_req) begin
                r_lead++;
            end
            if (mem_read_o) r_rd_seen = 1'b1;
            if (mem_write_o) r_wr_seen = 1'b1;
            if (cpu_rdata_valid_o) begin
                r_vld++;
                r_vld_data = cpu_rdata_o;
            end
            if (!stall_o) begin
                r_ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_write_i = 1'b0; cpu_read_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        #3;
        check("rst_stall", stall_o, 0);
        check("rst_mem_read", mem_read_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_rdata", cpu_rdata_o, 0);
        check("rst_valid", cpu_rdata_valid_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Store 0xDEADBEEF to 0x10.
        run_op(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        idle_inputs();
        check("st_done", r_ok, 1);
        check("st_stall_cycles", r_stall, 4);
        check("st_write_cycles", r_req, 4);
        check("st_no_read", r_rd_seen, 0);
        check("st_no_valid", r_vld, 0);
        @(negedge clk_i);
        check("st_mem", mem[8'h10], 32'hDEAD_BEEF);
        check("st_idle_write", mem_write_o, 0);
        check("st_idle_stall", stall_o, 0);
        @(posedge clk_i);
        #1;

        // Load it back.
        run_op(1'b0, 1'b1, 32'h10, 32'h0);
        idle_inputs();
        check("ld_done", r_ok, 1);
        check("ld_stall_cycles", r_stall, 5);
        check("ld_read_cycles", r_req, 4);
        check("ld_valid_pulses", r_vld, 1);
        check("ld_valid_data", r_vld_data, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("ld_hold_data", cpu_rdata_o, 32'hDEAD_BEEF);
        check("ld_valid_low", cpu_rdata_valid_o, 0);
        @(posedge clk_i);
        #1;

        // Back-to-back store then load with requests held.
        run_op(1'b1, 1'b0, 32'h20, 32'h1234_5678);
        check("b2b_st_stall", r_stall, 4);
        check("b2b_st_last_req", r_last_req, 1);
        run_op(1'b0, 1'b1, 32'h20, 32'h0);
        idle_inputs();
        check("b2b_gap", r_lead, 1);
        check("b2b_ld_stall", r_stall, 5);
        check("b2b_ld_data", r_vld_data, 32'h1234_5678);
        check("b2b_mem", mem[8'h20], 32'h1234_5678);

        // Both requests high: write wins.
        run_op(1'b1, 1'b1, 32'h4, 32'h55);
        idle_inputs();
        check("both_write_seen", r_wr_seen, 1);
        check("both_read_seen", r_rd_seen, 0);
        check("both_valid", r_vld, 0);
        check("both_stall", r_stall, 4);
        @(negedge clk_i);
        check("both_mem", mem[8'h4], 32'h55);
        check("both_valid_after", cpu_rdata_valid_o, 0);
        @(posedge clk_i);
        #1;

        // Reset in the middle of a read access.
        cpu_read_i = 1'b1; cpu_addr_i = 32'h10;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_read_active", mem_read_o, 1);
        #1;
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check("mid_rst_read", mem_read_o, 0);
        check("mid_rst_addr", mem_addr_o, 0);
        check("mid_rst_stall", stall_o, 0);
        check("mid_rst_rdata", cpu_rdata_o, 0);
        check("mid_rst_valid", cpu_rdata_valid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_op(1'b0, 1'b1, 32'h10, 32'h0);
        idle_inputs();
        check("post_rst_done", r_ok, 1);
        check("post_rst_data", r_vld_data, 32'hDEAD_BEEF);
        check("post_rst_stall", r_stall, 5);

`ifdef DMEM_TIMEOUT_EN
        // RAM never drops busy: abort after 8 ACCESS cycles.
        busy_forever = 1'b1;
        run_op(1'b0, 1'b1, 32'h20, 32'h0);
        idle_inputs();
        check("to_done", r_ok, 1);
        check("to_req_cycles", r_req, 8);
        check("to_stall_cycles", r_stall, 8);
        check("to_valid", r_vld, 0);
        check("to_err", err_o, 1);
        check("to_read_low", mem_read_o, 0);
        busy_forever = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("to_err_sticky", err_o, 1);
        check("to_rdata_kept", cpu_rdata_o, 32'hDEAD_BEEF);
        check("to_stall_low", stall_o, 0);
`else
        @(negedge clk_i);
        check("no_to_err", err_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
